// File: rtl/cache_mshr.sv
// Single-entry miss-status holding register: critical-word-first refill from memory,
// victim line capture, and write-back of a dirty victim once the refill is complete.
module cache_mshr #(
    parameter int unsigned WORD_WIDTH        = 32,
    parameter int unsigned ADR_WIDTH         = 32,
    parameter int unsigned WORD_OFFSET_WIDTH = 2,
    parameter int unsigned BYTE_OFFSET_WIDTH = 2
) (
    input  logic                                                     clk,
    input  logic                                                     rst,
    input  logic                                                     miss_req_i,
    input  logic [ADR_WIDTH-1:0]                                     miss_adr_i,
    input  logic [ADR_WIDTH-WORD_OFFSET_WIDTH-BYTE_OFFSET_WIDTH-1:0] victim_adr_i,
    input  logic                                                     victim_dirty_i,
    input  logic                                                     victim_vld_i,
    input  logic [WORD_OFFSET_WIDTH-1:0]                             victim_word_i,
    input  logic [WORD_WIDTH-1:0]                                    victim_dat_i,
    output logic                                                     refill_vld_o,
    output logic [WORD_OFFSET_WIDTH-1:0]                             refill_word_o,
    output logic [WORD_WIDTH-1:0]                                    refill_dat_o,
    output logic                                                     busy_o,
    output logic                                                     done_o,
    output logic                                                     mem_req_o,
    output logic                                                     mem_rdwr_o,
    output logic [ADR_WIDTH-1:0]                                     mem_adr_o,
    output logic [WORD_WIDTH-1:0]                                    mem_dat_o,
    input  logic                                                     mem_ack_i,
    input  logic [WORD_WIDTH-1:0]                                    mem_dat_i
);

    localparam int unsigned OFF_WIDTH  = WORD_OFFSET_WIDTH + BYTE_OFFSET_WIDTH;
    localparam int unsigned LINE_WIDTH = ADR_WIDTH - OFF_WIDTH;
    localparam int unsigned WORD_NUM   = 2 ** WORD_OFFSET_WIDTH;

    typedef enum logic [2:0] {StIdle, StFetch, StWbWait, StWriteback, StDone} state_e;

    state_e                         state_q, state_d;
    logic [LINE_WIDTH-1:0]          line_q, line_d;
    logic [LINE_WIDTH-1:0]          vadr_q, vadr_d;
    logic [WORD_OFFSET_WIDTH-1:0]   crit_q, crit_d;
    logic [WORD_OFFSET_WIDTH-1:0]   beat_q, beat_d;
    logic                           dirty_q, dirty_d;
    logic [WORD_NUM-1:0]            mask_q, mask_d;
    logic [WORD_WIDTH-1:0]          vbuf_q [WORD_NUM];
    logic [WORD_WIDTH-1:0]          vbuf_d [WORD_NUM];

    logic                           refill_vld_q, refill_vld_d;
    logic [WORD_OFFSET_WIDTH-1:0]   refill_word_q, refill_word_d;
    logic [WORD_WIDTH-1:0]          refill_dat_q, refill_dat_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           mem_req_q, mem_req_d;
    logic                           mem_rdwr_q, mem_rdwr_d;
    logic [ADR_WIDTH-1:0]           mem_adr_q, mem_adr_d;
    logic [WORD_WIDTH-1:0]          mem_dat_q, mem_dat_d;

    logic                           ack;
    logic [WORD_OFFSET_WIDTH-1:0]   fetch_word;

    assign ack = mem_ack_i && mem_req_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            line_q        <= '0;
            vadr_q        <= '0;
            crit_q        <= '0;
            beat_q        <= '0;
            dirty_q       <= 1'b0;
            mask_q        <= '0;
            refill_vld_q  <= 1'b0;
            refill_word_q <= '0;
            refill_dat_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_rdwr_q    <= 1'b0;
            mem_adr_q     <= '0;
            mem_dat_q     <= '0;
        end else begin
            state_q       <= state_d;
            line_q        <= line_d;
            vadr_q        <= vadr_d;
            crit_q        <= crit_d;
            beat_q        <= beat_d;
            dirty_q       <= dirty_d;
            mask_q        <= mask_d;
            refill_vld_q  <= refill_vld_d;
            refill_word_q <= refill_word_d;
            refill_dat_q  <= refill_dat_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            mem_req_q     <= mem_req_d;
            mem_rdwr_q    <= mem_rdwr_d;
            mem_adr_q     <= mem_adr_d;
            mem_dat_q     <= mem_dat_d;
        end
    end

    // Victim data is qualified by mask_q, so the buffer itself needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WORD_NUM; i++) begin
            vbuf_q[i] <= vbuf_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        vadr_d  = vadr_q;
        crit_d  = crit_q;
        beat_d  = beat_q;
        dirty_d = dirty_q;
        mask_d  = mask_q;
        vbuf_d  = vbuf_q;

        if (state_q != StIdle && victim_vld_i) begin
            vbuf_d[victim_word_i] = victim_dat_i;
            mask_d[victim_word_i] = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                // busy_q is still high during the done_o cycle; a miss there is dropped.
                if (miss_req_i && !busy_q) begin
                    line_d  = miss_adr_i[ADR_WIDTH-1:OFF_WIDTH];
                    crit_d  = miss_adr_i[OFF_WIDTH-1:BYTE_OFFSET_WIDTH];
                    vadr_d  = victim_adr_i;
                    dirty_d = victim_dirty_i;
                    mask_d  = '0;
                    beat_d  = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (ack) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == '1) begin
                        if (!dirty_q)      state_d = StDone;
                        else if (&mask_d)  state_d = StWriteback;
                        else               state_d = StWbWait;
                    end
                end
            end
            StWbWait: begin
                if (&mask_d) state_d = StWriteback;
            end
            StWriteback: begin
                if (ack) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == '1) state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign fetch_word = crit_d + beat_d;

    // Outputs are registered: next values are derived from the next state.
    always_comb begin
        refill_vld_d  = (state_q == StFetch) && ack;
        refill_word_d = refill_vld_d ? crit_q + beat_q : '0;
        refill_dat_d  = refill_vld_d ? mem_dat_i : '0;
        busy_d        = (state_d != StIdle) || (state_q == StDone);
        done_d        = (state_q == StDone);
        mem_req_d     = (state_d == StFetch) || (state_d == StWriteback);
        mem_rdwr_d    = (state_d == StWriteback);
        mem_adr_d     = '0;
        mem_dat_d     = '0;
        if (state_d == StFetch) begin
            mem_adr_d = {line_d, fetch_word, {BYTE_OFFSET_WIDTH{1'b0}}};
        end else if (state_d == StWriteback) begin
            mem_adr_d = {vadr_d, beat_d, {BYTE_OFFSET_WIDTH{1'b0}}};
            // Hold write data while waiting, even if the victim word is rewritten.
            mem_dat_d = (state_q != StWriteback || ack) ? vbuf_d[beat_d] : mem_dat_q;
        end
    end

    assign refill_vld_o  = refill_vld_q;
    assign refill_word_o = refill_word_q;
    assign refill_dat_o  = refill_dat_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign mem_req_o     = mem_req_q;
    assign mem_rdwr_o    = mem_rdwr_q;
    assign mem_adr_o     = mem_adr_q;
    assign mem_dat_o     = mem_dat_q;

endmodule

// File: tb/tb_cache_mshr.sv
// Directed bench for cache_mshr: a scripted memory responder and victim driver run
// one miss per call; logged beats and refills are compared to hand-computed values.
module tb_cache_mshr;

    logic        clk;
    logic        rst;
    logic        miss_req_i;
    logic [31:0] miss_adr_i;
    logic [27:0] victim_adr_i;
    logic        victim_dirty_i;
    logic        victim_vld_i;
    logic [1:0]  victim_word_i;
    logic [31:0] victim_dat_i;
    logic        refill_vld_o;
    logic [1:0]  refill_word_o;
    logic [31:0] refill_dat_o;
    logic        busy_o;
    logic        done_o;
    logic        mem_req_o;
    logic        mem_rdwr_o;
    logic [31:0] mem_adr_o;
    logic [31:0] mem_dat_o;
    logic        mem_ack_i;
    logic [31:0] mem_dat_i;

    cache_mshr dut (
        .clk            (clk),
        .rst            (rst),
        .miss_req_i     (miss_req_i),
        .miss_adr_i     (miss_adr_i),
        .victim_adr_i   (victim_adr_i),
        .victim_dirty_i (victim_dirty_i),
        .victim_vld_i   (victim_vld_i),
        .victim_word_i  (victim_word_i),
        .victim_dat_i   (victim_dat_i),
        .refill_vld_o   (refill_vld_o),
        .refill_word_o  (refill_word_o),
        .refill_dat_o   (refill_dat_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .mem_req_o      (mem_req_o),
        .mem_rdwr_o     (mem_rdwr_o),
        .mem_adr_o      (mem_adr_o),
        .mem_dat_o      (mem_dat_o),
        .mem_ack_i      (mem_ack_i),
        .mem_dat_i      (mem_dat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scenario knobs
    int          lat;
    int          vic_t [4];
    int          dup_t;
    logic [31:0] dup_adr;
    int          rst_t;

    // Per-run logs
    int          beat_n, ref_n, done_n, done_t, first_wr_t, unstable;
    logic [31:0] beat_adr [16];
    logic [31:0] beat_dat [16];
    logic        beat_wr  [16];
    logic [1:0]  ref_word [8];
    logic [31:0] ref_dat  [8];
    int          ref_t    [8];
    logic [4:0]  rst_snap;
    logic [31:0] rst_adr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_knobs(input int l, input int v0, input int v1, input int v2,
                             input int v3, input int d, input int r);
        lat      = l;
        vic_t[0] = v0;
        vic_t[1] = v1;
        vic_t[2] = v2;
        vic_t[3] = v3;
        dup_t    = d;
        rst_t    = r;
    endtask

    // t counts negedges from the one where miss_req_i is raised (t=0).
    task automatic run_miss(input logic [31:0] adr, input logic [27:0] vadr,
                            input logic dirty, input int budget);
        int          t;
        int          wait_cnt;
        int          tail;
        logic        prev_req;
        logic        prev_ack;
        logic [31:0] prev_adr;
        logic [31:0] prev_dat;
        beat_n = 0; ref_n = 0; done_n = 0; done_t = -1; first_wr_t = -1; unstable = 0;
        rst_snap = '1; rst_adr = '1;
        @(negedge clk);
        miss_req_i     = 1'b1;
        miss_adr_i     = adr;
        victim_adr_i   = vadr;
        victim_dirty_i = dirty;
        t = 0; wait_cnt = 0; tail = -1; prev_req = 1'b0; prev_ack = 1'b0;
        prev_adr = '0; prev_dat = '0;
        while (t < budget && tail != 0) begin
            @(negedge clk);
            t++;
            miss_req_i = (t == dup_t);
            miss_adr_i = (t == dup_t) ? dup_adr : adr;
            rst        = (t == rst_t);
            if (t == rst_t + 1) begin
                rst_snap = {busy_o, done_o, mem_req_o, refill_vld_o, mem_rdwr_o};
                rst_adr  = mem_adr_o;
            end
            if (refill_vld_o && ref_n < 8) begin
                ref_word[ref_n] = refill_word_o;
                ref_dat[ref_n]  = refill_dat_o;
                ref_t[ref_n]    = t;
                ref_n++;
            end
            if (done_o) begin
                done_n++;
                done_t = t;
                tail   = 3;
            end
            if (mem_req_o && mem_rdwr_o && first_wr_t < 0) first_wr_t = t;
            if (t != rst_t + 1 && prev_req && !prev_ack &&
                (!mem_req_o || mem_adr_o != prev_adr || mem_dat_o != prev_dat)) unstable++;
            mem_ack_i = 1'b0;
            mem_dat_i = '0;
            if (mem_req_o && !rst) begin
                if (wait_cnt == lat) begin
                    mem_ack_i = 1'b1;
                    mem_dat_i = mem_rdwr_o ? 32'h0 : (32'hD000_0000 ^ mem_adr_o);
                    if (beat_n < 16) begin
                        beat_adr[beat_n] = mem_adr_o;
                        beat_dat[beat_n] = mem_dat_o;
                        beat_wr[beat_n]  = mem_rdwr_o;
                    end
                    beat_n++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
            prev_req = mem_req_o;
            prev_ack = mem_ack_i;
            prev_adr = mem_adr_o;
            prev_dat = mem_dat_o;
            victim_vld_i  = 1'b0;
            victim_word_i = '0;
            victim_dat_i  = '0;
            for (int w = 0; w < 4; w++) begin
                if (vic_t[w] == t) begin
                    victim_vld_i  = 1'b1;
                    victim_word_i = w[1:0];
                    victim_dat_i  = 32'hA0 + w;
                end
            end
            if (tail > 0) tail--;
        end
        miss_req_i = 1'b0; rst = 1'b0; mem_ack_i = 1'b0; mem_dat_i = '0;
        victim_vld_i = 1'b0; victim_dirty_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; miss_req_i = 1'b0; miss_adr_i = '0; victim_adr_i = '0;
        victim_dirty_i = 1'b0; victim_vld_i = 1'b0; victim_word_i = '0; victim_dat_i = '0;
        mem_ack_i = 1'b0; mem_dat_i = '0; dup_adr = 32'h0000_7770;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {31'h0, busy_o | done_o | mem_req_o | refill_vld_o | mem_rdwr_o}, 0);
        check("reset_adr", mem_adr_o | mem_dat_o | refill_dat_o, 0);
        rst = 1'b0;

        // 1: clean miss, critical word 2
        set_knobs(0, -1, -1, -1, -1, -1, -1);
        run_miss(32'h0000_1238, 28'h0, 1'b0, 40);
        check("t1_beats", beat_n, 4);
        check("t1_adr0", beat_adr[0], 32'h1238);
        check("t1_adr1", beat_adr[1], 32'h123C);
        check("t1_adr2", beat_adr[2], 32'h1230);
        check("t1_adr3", beat_adr[3], 32'h1234);
        check("t1_rd", {31'h0, beat_wr[0] | beat_wr[3]}, 0);
        check("t1_refills", ref_n, 4);
        check("t1_words", {24'h0, ref_word[0], ref_word[1], ref_word[2], ref_word[3]}, 32'hB1);
        check("t1_dat0", ref_dat[0], 32'hD000_1238);
        check("t1_dat3", ref_dat[3], 32'hD000_1234);
        check("t1_done_n", done_n, 1);
        check("t1_done_lag", done_t - ref_t[3], 1);
        check("t1_no_wr", first_wr_t, -1);

        // 2: dirty miss, victim complete before the fetch ends
        set_knobs(0, 1, 2, 3, 4, -1, -1);
        run_miss(32'h0000_5670, 28'h0000ABC, 1'b1, 40);
        check("t2_beats", beat_n, 8);
        check("t2_rd3", {beat_wr[3], beat_adr[3][30:0]}, 32'h567C);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_wadr%0d", k), {31'h0, beat_wr[4+k]} << 16 | beat_adr[4+k],
                  32'h0001_ABC0 + 32'(4 * k));
            check($sformatf("t2_wdat%0d", k), beat_dat[4+k], 32'hA0 + 32'(k));
        end
        check("t2_first_wr", first_wr_t, 5);
        check("t2_done_t", done_t, 10);

        // 3: slow memory, ack three cycles after each request
        set_knobs(3, -1, -1, -1, -1, -1, -1);
        run_miss(32'h0000_2000, 28'h0, 1'b0, 60);
        check("t3_refills", ref_n, 4);
        check("t3_unstable", unstable, 0);
        check("t3_adr2", beat_adr[2], 32'h2008);
        check("t3_ref_t0", ref_t[0], 5);
        check("t3_done_t", done_t, 18);

        // 4: dirty victim whose last word is late
        set_knobs(0, 1, 2, 3, 9, -1, -1);
        run_miss(32'h0000_8000, 28'h00000DE, 1'b1, 40);
        check("t4_first_wr", first_wr_t, 10);
        check("t4_beats", beat_n, 8);
        check("t4_wadr0", beat_adr[4], 32'h0DE0);
        check("t4_wdat3", beat_dat[7], 32'hA3);
        check("t4_done_t", done_t, 15);

        // 5: second miss while busy is ignored, then served after done
        set_knobs(0, -1, -1, -1, -1, 2, -1);
        run_miss(32'h0000_3334, 28'h0, 1'b0, 40);
        check("t5_beats", beat_n, 4);
        check("t5_adr0", beat_adr[0], 32'h3334);
        check("t5_adr3", beat_adr[3], 32'h3330);
        check("t5_done_n", done_n, 1);
        set_knobs(0, -1, -1, -1, -1, -1, -1);
        run_miss(32'h0000_7770, 28'h0, 1'b0, 40);
        check("t5_next_adr0", beat_adr[0], 32'h7770);
        check("t5_next_beats", beat_n, 4);

        // 6: reset during the second read beat aborts the miss
        set_knobs(0, -1, -1, -1, -1, -1, 2);
        run_miss(32'h0000_4448, 28'h0, 1'b0, 12);
        check("t6_snap", {27'h0, rst_snap}, 0);
        check("t6_snap_adr", rst_adr, 0);
        check("t6_no_done", done_n, 0);
        check("t6_beats", beat_n, 1);
        set_knobs(0, -1, -1, -1, -1, -1, -1);
        run_miss(32'h0000_4448, 28'h0, 1'b0, 40);
        check("t6_again_adr0", beat_adr[0], 32'h4448);
        check("t6_again_word0", {30'h0, ref_word[0]}, 2);
        check("t6_again_done", done_n, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
